// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory block-transfer engine.
//   state_e    : transfer FSM states (idle, read, write, done)
//   MEM_AW/DW  : memory byte-address and data-word widths
//   WORD_BYTES : byte stride of one 16-bit word
package mem_pkg;

  localparam int unsigned MEM_AW     = 16;
  localparam int unsigned MEM_DW     = 16;
  localparam int unsigned WORD_BYTES = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-transfer initiator on the master side of the byte-addressed 16-bit data memory.
// Copies len words from src to dst (mode=0) or fills len words at dst with fill_val (mode=1).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, mode, src,
//   dst, len, fill_val  : transfer request; operands captured when start is accepted in idle
//   abort               : end the transfer at the next edge (read/write states only)
//   busy, done, aborted : status; done is a one-cycle pulse, aborted is valid with done
//   words_done, csum    : words written so far and their mod-2^16 sum
//   mem_addr, mem_wdata,
//   mem_we, mem_rdata   : memory master port; mem_rdata is combinational for mem_addr
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [MEM_AW-1:0] src,
  input  logic [MEM_AW-1:0] dst,
  input  logic [CNT_W-1:0]  len,
  input  logic [MEM_DW-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  words_done,
  output logic [MEM_DW-1:0] csum,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [MEM_DW-1:0] mem_rdata
);

  localparam logic [MEM_AW-1:0] Step = MEM_AW'(WORD_BYTES);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [MEM_AW-1:0] src_q, src_d;
  logic [MEM_AW-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [MEM_DW-1:0] fill_q, fill_d;
  logic [MEM_DW-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [MEM_DW-1:0] csum_q, csum_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;

  // Word presented on the bus in the write state.
  logic [MEM_DW-1:0] wr_word;
  assign wr_word = mode_q ? fill_q : buf_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    fill_d    = fill_q;
    buf_d     = buf_q;
    words_d   = words_q;
    csum_d    = csum_q;
    aborted_d = aborted_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode;
          src_d     = src;
          dst_d     = dst;
          len_d     = len;
          fill_d    = fill_val;
          words_d   = '0;
          csum_d    = '0;
          aborted_d = 1'b0;
          if (len == '0) begin
            state_d = StDone;
          end else if (mode) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        buf_d = mem_rdata;
        src_d = src_q + Step;
        if (abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        // The write in this cycle commits even when aborted, so it is always counted.
        dst_d   = dst_q + Step;
        words_d = words_q + CNT_W'(1);
        csum_d  = csum_q + wr_word;
        if (abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else if (words_d == len_q) begin
          state_d = StDone;
        end else if (mode_q) begin
          state_d = StWrite;
        end else begin
          state_d = StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StRead) || (state_d == StWrite);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      buf_q     <= '0;
      words_q   <= '0;
      csum_q    <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      fill_q    <= fill_d;
      buf_q     <= buf_d;
      words_q   <= words_d;
      csum_q    <= csum_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
    end
  end

  // Memory port decoded from registered state only; no path from start.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      StRead: begin
        mem_addr = src_q;
      end
      StWrite: begin
        mem_addr  = dst_q;
        mem_wdata = wr_word;
        mem_we    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = (state_q == StDone);
  assign aborted    = aborted_q;
  assign words_done = words_q;
  assign csum       = csum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural byte memory as responder, a
// transfer-level model that predicts every cycle's outputs, plus literal expectations.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, abort;
  logic [15:0] src, dst, len, fill_val;
  logic        busy, done, aborted, mem_we;
  logic [15:0] words_done, csum, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_copy_engine #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .fill_val   (fill_val),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .words_done (words_done),
    .csum       (csum),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- memory responder ----------------
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h0100, 16'h0101: init_byte = 8'h11;
      16'h0102, 16'h0103: init_byte = 8'h22;
      16'h0104, 16'h0105: init_byte = 8'h33;
      16'hFFFE: init_byte = 8'h34;
      16'hFFFF: init_byte = 8'h12;
      16'h0000: init_byte = 8'h78;
      16'h0001: init_byte = 8'h56;
      16'h3000: init_byte = 8'hAB;
      16'h3001: init_byte = 8'hCD;
      default:  init_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  logic [7:0]  mem [0:65535];
  bit          wr  [0:65535];
  logic [15:0] a1;
  assign a1 = mem_addr + 16'd1;
  assign mem_rdata = {(wr[a1] ? mem[a1] : init_byte(a1)),
                      (wr[mem_addr] ? mem[mem_addr] : init_byte(mem_addr))};

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata[7:0];
      wr[mem_addr]  <= 1'b1;
      mem[a1]       <= mem_wdata[15:8];
      wr[a1]        <= 1'b1;
    end
  end

  function automatic logic [7:0] rd(input logic [15:0] a);
    rd = wr[a] ? mem[a] : init_byte(a);
  endfunction

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_abs = 0;
  int we_cnt = 0;
  logic [15:0] addr_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output vector layout: busy,done,aborted,we,addr[63:48],wdata[47:32],words[31:16],csum[15:0]
  function automatic logic [67:0] pk(input logic b, input logic d, input logic ab,
                                     input logic we, input logic [15:0] ad,
                                     input logic [15:0] wd, input logic [15:0] wc,
                                     input logic [15:0] cs);
    pk = {b, d, ab, we, ad, wd, wc, cs};
  endfunction

  // ---------------- transfer model ----------------
  typedef struct {
    logic [67:0] v;
    bit          skip_wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [0:65535];

  function automatic void push(input logic [67:0] v, input bit skip);
    exp_t e;
    e.v = v;
    e.skip_wdata = skip;
    exp_q.push_back(e);
  endfunction

  // Predicts every cycle from cycle 1 after the start edge up to the idle cycle after done.
  function automatic void build(input logic m, input logic [15:0] s0, input logic [15:0] d0,
                                input logic [15:0] n, input logic [15:0] fv,
                                input int abort_k);
    logic [15:0] s, d, val, wc, cs;
    bit ab;
    s = s0; d = d0; wc = 0; cs = 0; ab = 0;
    for (int k = 0; k < int'(n); k++) begin
      if (!m) begin
        val = {ref_mem[s + 16'd1], ref_mem[s]};
        push(pk(1'b1, 1'b0, 1'b0, 1'b0, s, 16'h0, wc, cs), 1'b1);
        s = s + 16'd2;
      end else begin
        val = fv;
      end
      push(pk(1'b1, 1'b0, 1'b0, 1'b1, d, val, wc, cs), 1'b0);
      ref_mem[d]         = val[7:0];
      ref_mem[d + 16'd1] = val[15:8];
      d  = d + 16'd2;
      wc = wc + 16'd1;
      cs = cs + val;
      if (k == abort_k) begin
        ab = 1;
        break;
      end
    end
    push(pk(1'b0, 1'b1, ab, 1'b0, 16'h0, 16'h0, wc, cs), 1'b0);
    push(pk(1'b0, 1'b0, ab, 1'b0, 16'h0, 16'h0, wc, cs), 1'b0);
  endfunction

  // ---------------- compare process ----------------
  exp_t        e_cur;
  logic [67:0] act_v, mask_v;
  always @(negedge clk) begin
    if (done === 1'b1) done_abs = cyc;
    if (mem_we === 1'b1) we_cnt++;
    if (busy === 1'b1) addr_log.push_back(mem_addr);
    if (exp_q.size() > 0) begin
      e_cur  = exp_q.pop_front();
      mask_v = {68{1'b1}};
      if (e_cur.skip_wdata) mask_v[47:32] = 16'h0;
      act_v = pk(busy, done, aborted, mem_we, mem_addr, mem_wdata, words_done, csum);
      chk("cycle", act_v & mask_v, e_cur.v & mask_v);
    end
  end

  // ---------------- stimulus ----------------
  int we_base, log_base;

  task automatic start_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input logic [15:0] fv,
                            input int abort_k, input bit use_model);
    start = 1'b1; mode = m; src = s; dst = d; len = n; fill_val = fv;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    done_abs = 0;
    we_base = we_cnt;
    log_base = addr_log.size();
    if (use_model) build(m, s, d, n, fv, abort_k);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    chk("timeout", 68'(exp_q.size()), 68'd0);
    exp_q.delete();
    #1;
  endtask

  function automatic int done_rel();
    done_rel = (done_abs == 0) ? -1 : done_abs - start_cyc + 1;
  endfunction

  int bad;
  logic [63:0] alog;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    rst_n = 1'b0; start = 0; mode = 0; abort = 0;
    src = 0; dst = 0; len = 0; fill_val = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", pk(busy, done, aborted, mem_we, mem_addr, mem_wdata, words_done, csum),
        68'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Copy 3 words 0x0100 -> 0x0200.
    start_xfer(1'b0, 16'h0100, 16'h0200, 16'd3, 16'h0, -1, 1'b1);
    wait_idle();
    chk("copy_data", {20'h0, rd(16'h0205), rd(16'h0204), rd(16'h0203), rd(16'h0202),
                      rd(16'h0201), rd(16'h0200)}, 68'h333322221111);
    chk("copy_done_cycle", 68'(done_rel()), 68'd7);
    chk("copy_words", 68'(words_done), 68'd3);
    chk("copy_csum", 68'(csum), 68'h6666);

    // Fill 4 words at 0x0010.
    start_xfer(1'b1, 16'h0000, 16'h0010, 16'd4, 16'hA5C3, -1, 1'b1);
    wait_idle();
    chk("fill_data", {4'h0, rd(16'h0017), rd(16'h0016), rd(16'h0015), rd(16'h0014),
                      rd(16'h0013), rd(16'h0012), rd(16'h0011), rd(16'h0010)},
        68'hA5C3A5C3A5C3A5C3);
    chk("fill_done_cycle", 68'(done_rel()), 68'd5);
    chk("fill_csum", 68'(csum), 68'h970C);

    // Source pointer wraps past 0xFFFE.
    start_xfer(1'b0, 16'hFFFE, 16'h0300, 16'd2, 16'h0, -1, 1'b1);
    wait_idle();
    chk("wrap_data", {36'h0, rd(16'h0303), rd(16'h0302), rd(16'h0301), rd(16'h0300)},
        68'h56781234);
    alog = 64'h0;
    for (int i = 0; i < 4; i++)
      if (log_base + i < addr_log.size()) alog = {alog[47:0], addr_log[log_base + i]};
    chk("wrap_addr_seq", {4'h0, alog}, 68'hFFFE030000000302);

    // Zero length.
    start_xfer(1'b0, 16'h0400, 16'h0500, 16'd0, 16'h0, -1, 1'b1);
    wait_idle();
    chk("len0_done_cycle", 68'(done_rel()), 68'd1);
    chk("len0_no_busy", 68'(addr_log.size() - log_base), 68'd0);
    chk("len0_no_write", 68'(we_cnt - we_base), 68'd0);

    // Abort in the 3rd write cycle (cycle 6) of a 10-word copy.
    start_xfer(1'b0, 16'h1000, 16'h2000, 16'd10, 16'h0, 2, 1'b1);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_idle();
    chk("abort_words", 68'(words_done), 68'd3);
    chk("abort_flag", 68'(aborted), 68'd1);
    chk("abort_done_cycle", 68'(done_rel()), 68'd7);
    bad = 0;
    for (int i = 6; i < 20; i++)
      if (rd(16'h2000 + 16'(i)) !== init_byte(16'h2000 + 16'(i))) bad++;
    chk("abort_untouched", 68'(bad), 68'd0);

    // Overlapping forward copy; start while busy and start in the done cycle are ignored.
    start_xfer(1'b0, 16'h3000, 16'h3002, 16'd3, 16'h0, -1, 1'b1);
    @(posedge clk);
    #1 start = 1'b1; mode = 1'b1; dst = 16'h0000; len = 16'd0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    chk("overlap_data", {20'h0, rd(16'h3007), rd(16'h3006), rd(16'h3005), rd(16'h3004),
                         rd(16'h3003), rd(16'h3002)}, 68'hCDABCDABCDAB);
    chk("aborted_cleared", 68'(aborted), 68'd0);

    // Reset during a write cycle, then retry.
    start_xfer(1'b0, 16'h0100, 16'h4000, 16'd4, 16'h0, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_mid_xfer",
        pk(busy, done, aborted, mem_we, mem_addr, mem_wdata, words_done, csum), 68'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_quiet", {65'h0, busy, done, mem_we}, 68'h0);
    end
    start_xfer(1'b0, 16'h0100, 16'h4100, 16'd3, 16'h0, -1, 1'b1);
    wait_idle();
    chk("retry_data", {20'h0, rd(16'h4105), rd(16'h4104), rd(16'h4103), rd(16'h4102),
                       rd(16'h4101), rd(16'h4100)}, 68'h333322221111);
    chk("retry_words", 68'(words_done), 68'd3);
    chk("retry_done_cycle", 68'(done_rel()), 68'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
